lut_arb_ctrl: RTL
=================

LUT_ARB_CTRL -- requirements
Module: lut_arb_ctrl

Interface
REQ-001 SHALL have parameter LUT_LAT, default 1: cycles lut_x/lut_en are held before lut_y is captured; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port req, input, 4: request per requester i = 0..3.
REQ-005 SHALL have port code, input, 16: requester i code on code[4i+3:4i].
REQ-006 SHALL have port gnt, output, 4: one-hot grant, high for the whole service window.
REQ-007 SHALL have port lut_en, output, 1: enable to the shared 4-bit -> 3-bit classifier lookup.
REQ-008 SHALL have port lut_x, output, 4: code driven to the lookup.
REQ-009 SHALL have port lut_y, input, 3: lookup result.
REQ-010 SHALL have port rsp_valid, output, 1: one-cycle result pulse.
REQ-011 SHALL have port rsp_id, output, 2: index of the served requester, valid with rsp_valid.
REQ-012 SHALL have port rsp_data, output, 3: captured lut_y, valid with rsp_valid.
REQ-013 SHALL have port busy, output, 1: high in WAIT and DONE.

Function
REQ-014 SHALL implement FSM IDLE -> WAIT -> DONE -> IDLE, with all outputs registered.
REQ-015 IDLE: on the first edge with req != 0, SHALL select a winner (REQ-021), latch its code and index, load the counter with LUT_LAT, and enter WAIT.
REQ-016 WAIT: SHALL drive gnt[id]=1, lut_en=1, lut_x=latched code; counter decrements each edge.
REQ-017 WAIT: on the edge where the counter equals 1, SHALL capture lut_y into rsp_data, set rsp_valid=1 and rsp_id=id, clear gnt and lut_en, and enter DONE.
REQ-018 DONE: SHALL last exactly one cycle with rsp_valid=1 and no arbitration; on the next edge SHALL clear rsp_valid and enter IDLE.
REQ-019 Latency: rsp_valid SHALL be high in cycle LUT_LAT+1 after the grant edge; min 3 cycles req-edge to req-edge per transaction.
REQ-020 Handshake: the requester SHALL hold req until it sees rsp_valid with its id. If req drops during WAIT, the transaction still completes with the latched code. code changes after the grant edge SHALL be ignored.
REQ-021 Simultaneous requests: exactly one winner per arbitration, chosen per REQ-026/027.
REQ-022 Outside WAIT: lut_en=0, lut_x=0, gnt=0; rsp_id/rsp_data SHALL hold their last values.

Reset
REQ-023 rst=1 SHALL asynchronously force IDLE, gnt=0, lut_en=0, lut_x=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, counter=0, round-robin pointer=3.
REQ-024 Reset during WAIT or DONE SHALL abort the transaction with no rsp_valid pulse; arbitration SHALL resume on the first edge after rst falls.
REQ-025 LUT_LAT values outside 1..15 SHALL be treated as 1.

Configuration
REQ-026 With RR_ARB_EN defined: round-robin arbitration; the search starts at (last winner + 1) mod 4, and the pointer updates on each grant.
REQ-027 Without RR_ARB_EN: fixed priority, lowest index wins; no pointer register is synthesized.

Verification
REQ-028 The bench SHALL connect a lookup with 0001->100, 0011->010, 0000->001, 1111->000, and output 000 when lut_en=0.
REQ-029 Single request, LUT_LAT=1: req=0001, code0=0001 -> gnt=0001 for 1 cycle, then rsp_valid=1, rsp_id=0, rsp_data=100 for 1 cycle.
REQ-030 RR_ARB_EN, req=1111 held, codes {0000,0001,0011,1111} -> rsp_id sequence 0,1,2,3,0 and rsp_data 001,100,010,000,001.
REQ-031 No RR_ARB_EN, req=0110 held -> rsp_id always 1; requester 2 starves.
REQ-032 LUT_LAT=4, code0=0011 -> lut_en high exactly 4 cycles, rsp_data=010; code0 changed to 0001 mid-WAIT has no effect.
REQ-033 rst pulsed in the second WAIT cycle (LUT_LAT=4) -> all outputs 0 immediately and no rsp_valid; after release with req0 still high, a full transaction completes with rsp_id=0 (pointer reset).

Source files
------------

// File: rtl/lut_arb_ctrl.sv
// lut_arb_ctrl: arbitrates four requesters onto one shared 4->3 classifier lookup, one transaction at a time.
// Define RR_ARB_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).

module lut_arb_ctrl #(
    parameter int LUT_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] code,
    output logic [3:0]  gnt,
    output logic        lut_en,
    output logic [3:0]  lut_x,
    input  logic [2:0]  lut_y,
    output logic        rsp_valid,
    output logic [1:0]  rsp_id,
    output logic [2:0]  rsp_data,
    output logic        busy
);
    // Out-of-range latencies fall back to a single lookup cycle.
    localparam logic [3:0] LAT = (LUT_LAT < 1 || LUT_LAT > 15) ? 4'd1 : 4'(LUT_LAT);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [1:0] id;
    logic [1:0] win;

`ifdef RR_ARB_EN
    logic [1:0] ptr;

    // Scan farthest-to-nearest from ptr so the nearest requester after ptr wins.
    always_comb begin
        win = ptr + 2'd1;
        for (int k = 4; k >= 1; k--)
            if (req[ptr + 2'(k)]) win = ptr + 2'(k);
    end
`else
    always_comb begin
        win = 2'd0;
        for (int k = 3; k >= 0; k--)
            if (req[k]) win = 2'(k);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            id        <= '0;
            gnt       <= '0;
            lut_en    <= 1'b0;
            lut_x     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
`ifdef RR_ARB_EN
            ptr       <= 2'd3;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state  <= WAIT;
                        id     <= win;
                        gnt    <= 4'b0001 << win;
                        lut_en <= 1'b1;
                        lut_x  <= code[{win, 2'b00} +: 4];
                        cnt    <= LAT;
                        busy   <= 1'b1;
`ifdef RR_ARB_EN
                        ptr    <= win;
`endif
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // lut_y is a function of the registered lut_x, so it is stable here.
                    if (cnt == 4'd1) begin
                        rsp_data  <= lut_y;
                        rsp_valid <= 1'b1;
                        rsp_id    <= id;
                        gnt       <= '0;
                        lut_en    <= 1'b0;
                        lut_x     <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    lut_en    <= 1'b0;
                    lut_x     <= '0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
